step_pulse_gen: RTL and testbench
=================================

# step_pulse_gen

Generates clean single-cycle step strobes from the two raw tuning push-buttons of the DDS synthesizer. It is the producer side of the step-strobe interface: its `step_up` output drives the `up` input of the tuning-word incrementer, and `step_dn` drives the matching decrement path. Each button is synchronised and debounced. A short press yields exactly one step. Holding a button yields one step, then after a hold delay, repeated steps at a fixed rate.

## Interface
- `DEB_CYCLES`, default 50000: consecutive stable cycles required before a debounced level changes; minimum 1.
- `HOLD_CYCLES`, default 6000000: cycles from the first step of a press to the first auto-repeat step; minimum 1.
- `REPEAT_CYCLES`, default 1500000: cycles between auto-repeat steps; minimum 1.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `btn_up`, input, 1: raw asynchronous up button, active-high.
- `btn_dn`, input, 1: raw asynchronous down button, active-high.
- `step_up`, output, 1: one-cycle strobe, one increment step.
- `step_dn`, output, 1: one-cycle strobe, one decrement step.
- `active`, output, 1: high while a single button is held (states PRESS/REPEAT).

## Operation
- Per button: 2-flop synchroniser, then a debouncer.
  - The debouncer holds a stable level `db` (reset 0) and a counter.
  - The counter increments while the synchronised input differs from `db`, and clears when they are equal.
  - When the count reaches `DEB_CYCLES`, `db` toggles and the counter clears.
- FSM states: IDLE, PRESS, REPEAT, LOCK. Reset → IDLE.
- IDLE:
  - `db_up` rising while `db_dn`=0 → emit `step_up`, go to PRESS, load the timer with `HOLD_CYCLES`.
  - The symmetric case for down emits `step_dn`.
  - Both rising in the same cycle → go to LOCK, no step.
- PRESS/REPEAT: the timer decrements each cycle.
  - When the timer reaches 0 with the same button still down: emit a step in the latched direction, reload with `REPEAT_CYCLES`, state becomes REPEAT.
  - Release of the latched button → IDLE, no step, timer cleared.
  - The other button becoming down → LOCK, no step.
- LOCK: no steps. Return to IDLE only when both `db` levels are 0.
- `step_up` and `step_dn` are registered, never both high, and never high in consecutive cycles.
- Timer width is `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)`. Debounce counter width is `$clog2(DEB_CYCLES+1)`. Counters never wrap; they saturate at the load and compare values only.

## Timing
- Reset values: `step_up`=0, `step_dn`=0, `active`=0, both sync flops 0, both `db` 0, counters 0, state IDLE.
- Press latency: if the raw input is first sampled high at edge k and stays high, `step_up` is high in the cycle after edge k+DEB_CYCLES+2, which is DEB_CYCLES+3 cycles.
- First repeat: `HOLD_CYCLES` cycles after the first step. Subsequent repeats are every `REPEAT_CYCLES` cycles.
- Release latency: the `db` fall lands DEB_CYCLES+2 cycles after the raw release. The FSM returns to IDLE one cycle later.
- A repeat due in the same cycle that release is detected is suppressed; release wins.
- Glitches shorter than `DEB_CYCLES` cycles produce no step and no `db` change.
- `active` is registered, rises with the first step, and falls one cycle after the release is detected.
- Reset mid-operation:
  - Any step in the reset cycle is dropped and all state clears.
  - A button still held after reset is treated as a new press and yields one step after DEB_CYCLES+3 cycles.

## Structure
- Shared package `dds_pkg` holds the FSM state encoding (2 bits: IDLE=0, PRESS=1, REPEAT=2, LOCK=3) and the default timing constants, which the top level reuses for the incrementer clock-domain budget.
- Sub-module `btn_debounce` (parameter `DEB_CYCLES`; ports `clk`, `rst`, `raw`, `db`) contains the synchroniser and debouncer. It is instantiated twice. The FSM and timer live in `step_pulse_gen`.

## Test plan
All scenarios use DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Tap: raw `btn_up` high for 20 cycles, then low → exactly one `step_up` pulse, 7 cycles after the first high sample; no `step_dn`; `active` returns to 0.
- Glitch: raw `btn_dn` high for 3 cycles, 5 times with 2-cycle gaps → no steps; `db_dn` stays 0.
- Auto-repeat: `btn_up` held for 40 cycles → `step_up` at t0, t0+10, t0+13, t0+16, … until release is detected; no extra step after release.
- Both buttons:
  - Press up, then press down while up is held → steps stop and the state goes to LOCK.
  - Release up only → no steps.
  - Release both → IDLE.
  - A new down press gives one `step_dn`.
- Reset mid-hold: assert `rst` during REPEAT for 1 cycle while `btn_up` stays held → all outputs 0 in the next cycle; exactly one `step_up` 7 cycles after reset deasserts, then repeats resume after 10 cycles.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS tuning definitions: step-FSM state encoding and default button timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The default timing constants are also consumed by the incrementer side
// when budgeting its clock-domain timing, so they live here, not in a module.
package dds_pkg;

    // Step FSM state encoding, fixed at 2 bits so it can be probed externally.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } step_state_t;

    // Default timing at the nominal board clock.
    localparam int DEF_DEB_CYCLES    = 50000;
    localparam int DEF_HOLD_CYCLES   = 6000000;
    localparam int DEF_REPEAT_CYCLES = 1500000;

    // Larger of two integers; used to size the shared hold/repeat timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw push-button.
// Latency: db follows a stable raw change DEB_CYCLES+1 edges after first sample.
// Backpressure: none; level output, always valid.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   raw  - asynchronous button input, active-high
//   db   - debounced level (reset 0)
module btn_debounce
    import dds_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    // The count that, once incremented, reaches DEB_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive cycles where the synchronised input disagrees with
    // the held level; any agreement restarts the count so glitches shorter
    // than DEB_CYCLES never toggle db.  The counter tops out at CNT_LAST and
    // clears on the toggle, so it cannot wrap.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Turns the up/down tuning buttons into single-cycle step strobes with hold-to-repeat.
// Latency: first step DEB_CYCLES+3 cycles after first raw sample; repeats after HOLD, then every REPEAT.
// Backpressure: none; strobes are fire-and-forget to the tuning-word incrementer.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   btn_up   - raw up button (async, active-high)
//   btn_dn   - raw down button (async, active-high)
//   step_up  - one-cycle increment strobe (registered)
//   step_dn  - one-cycle decrement strobe (registered)
//   active   - high while exactly one button is held (PRESS/REPEAT)
module step_pulse_gen
    import dds_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic step_up,
    output logic step_dn,
    output logic active
);

    localparam int TMAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] REPEAT_LD = TW'(REPEAT_CYCLES);

    // ------------------------------------------------------------------
    // Debounced button levels
    // ------------------------------------------------------------------
    logic db_up;
    logic db_dn;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_up (
        .clk (clk),
        .rst (rst),
        .raw (btn_up),
        .db  (db_up)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_dn (
        .clk (clk),
        .rst (rst),
        .raw (btn_dn),
        .db  (db_dn)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    step_state_t   state_q;
    step_state_t   state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          dir_up_q;     // latched direction: 1 = up, 0 = down
    logic          dir_up_d;
    logic          db_up_prev_q;
    logic          db_dn_prev_q;
    logic          step_up_q;
    logic          step_up_d;
    logic          step_dn_q;
    logic          step_dn_d;
    logic          active_q;
    logic          active_d;

    logic up_rise;
    logic dn_rise;
    logic latched_db;
    logic other_db;
    logic step_recent;
    logic timer_due;

    assign up_rise     = db_up & ~db_up_prev_q;
    assign dn_rise     = db_dn & ~db_dn_prev_q;
    assign latched_db  = dir_up_q ? db_up : db_dn;
    assign other_db    = dir_up_q ? db_dn : db_up;
    assign step_recent = step_up_q | step_dn_q;

    // The timer fires on the cycle it would count down to zero, which puts
    // repeats exactly HOLD/REPEAT cycles apart.  With a load value of 1 that
    // would land right after the previous strobe, so a firing is held off
    // while the last cycle had a strobe and taken from zero one cycle later.
    assign timer_due = (timer_q <= TW'(1)) && !step_recent;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dir_up_d  = dir_up_q;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (up_rise && dn_rise) begin
                    state_d = ST_LOCK;
                end else if (up_rise) begin
                    // A down button already held makes this a two-button
                    // press, not a fresh up step.
                    if (db_dn) begin
                        state_d = ST_LOCK;
                    end else begin
                        step_up_d = 1'b1;
                        dir_up_d  = 1'b1;
                        timer_d   = HOLD_LD;
                        state_d   = ST_PRESS;
                    end
                end else if (dn_rise) begin
                    if (db_up) begin
                        state_d = ST_LOCK;
                    end else begin
                        step_dn_d = 1'b1;
                        dir_up_d  = 1'b0;
                        timer_d   = HOLD_LD;
                        state_d   = ST_PRESS;
                    end
                end
            end

            ST_PRESS, ST_REPEAT: begin
                // Priority: second button > release > repeat.  Release
                // outranks a repeat due in the same cycle so letting go
                // never adds a trailing step.  The second button outranks
                // release so a simultaneous swap parks in LOCK rather than
                // an IDLE that would never see the other button rise.
                if (other_db) begin
                    timer_d = '0;
                    state_d = ST_LOCK;
                end else if (!latched_db) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_due) begin
                    step_up_d = dir_up_q;
                    step_dn_d = ~dir_up_q;
                    timer_d   = REPEAT_LD;
                    state_d   = ST_REPEAT;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_LOCK: begin
                timer_d = '0;
                if (!db_up && !db_dn) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_PRESS) || (state_d == ST_REPEAT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            dir_up_q     <= 1'b0;
            db_up_prev_q <= 1'b0;
            db_dn_prev_q <= 1'b0;
            step_up_q    <= 1'b0;
            step_dn_q    <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dir_up_q     <= dir_up_d;
            db_up_prev_q <= db_up;
            db_dn_prev_q <= db_dn;
            step_up_q    <= step_up_d;
            step_dn_q    <= step_dn_d;
            active_q     <= active_d;
        end
    end

    assign step_up = step_up_q;
    assign step_dn = step_dn_q;
    assign active  = active_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with DEB=4, HOLD=10, REPEAT=3.
// Stimulus pushes expected strobes (edge number, direction); the monitor
// pops and compares whenever a strobe appears, or when one is overdue.
module tb_step_pulse_gen;
    import dds_pkg::*;

    localparam int DEB = 4;
    localparam int HLD = 10;
    localparam int REP = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_dn;
    logic step_up;
    logic step_dn;
    logic active;

    step_pulse_gen #(
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .step_up (step_up),
        .step_dn (step_dn),
        .active  (active)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; read on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic up;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_step = 1'b0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (step_up === 1'b1 || step_dn === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_step: cyc=%0d up=%0b dn=%0b, required no strobe",
                             cyc, step_up, step_dn);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.up != step_up) begin
                        n_bad++;
                        $display("FAIL step_match: got cyc=%0d up=%0b, required cyc=%0d up=%0b",
                                 cyc, step_up, mon_e.cyc, mon_e.up);
                    end
                end
                n_cmp++;
                if ((step_up && step_dn) || prev_step) begin
                    n_bad++;
                    $display("FAIL strobe_rule: cyc=%0d up=%0b dn=%0b prev=%0b, required single isolated strobe",
                             cyc, step_up, step_dn, prev_step);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_step: none by cyc=%0d, required cyc=%0d up=%0b",
                         cyc, exp_q[0].cyc, exp_q[0].up);
                void'(exp_q.pop_front());
            end
            prev_step = (step_up === 1'b1) || (step_dn === 1'b1);
        end
    end

    // ---------------- helpers ----------------
    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: cyc=%0d got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int c, input logic up);
        exp_t e;
        e.cyc = c;
        e.up  = up;
        exp_q.push_back(e);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int c;
    initial begin
        rst    = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        at(2);
        check("reset_step_up", 32'(step_up), 0);
        check("reset_step_dn", 32'(step_dn), 0);
        check("reset_active",  32'(active), 0);
        check("reset_state",   32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        at(5);

        // Tap: 8 cycles high -> one step 7 edges after driving.
        c = cyc;
        btn_up = 1'b1;
        push(c + 7, 1'b1);
        at(c + 6);  check("tap_active_pre",  32'(active), 0);
        at(c + 7);  check("tap_active_rise", 32'(active), 1);
        at(c + 8);  btn_up = 1'b0;
        at(c + 14); check("tap_active_hold", 32'(active), 1);
        at(c + 15); check("tap_active_fall", 32'(active), 0);
        at(c + 30);

        // Release detected on the same edge a repeat falls due: no repeat.
        c = cyc;
        btn_up = 1'b1;
        push(c + 7, 1'b1);
        at(c + 10); btn_up = 1'b0;
        at(c + 16); check("edge_active_hold", 32'(active), 1);
        at(c + 17); check("edge_active_fall", 32'(active), 0);
        at(c + 35);

        // Glitch: five 3-cycle pulses on down with 2-cycle gaps.
        c = cyc;
        for (int i = 0; i < 5; i++) begin
            at(c + 5 * i);     btn_dn = 1'b1;
            at(c + 5 * i + 3); btn_dn = 1'b0;
            check("glitch_db_dn", 32'(dut.db_dn), 0);
        end
        at(c + 35);
        check("glitch_db_dn_end", 32'(dut.db_dn), 0);
        check("glitch_active", 32'(active), 0);

        // Auto-repeat: hold up for 40 cycles.
        c = cyc;
        btn_up = 1'b1;
        push(c + 7, 1'b1);
        for (int i = 0; i < 10; i++) push(c + 17 + 3 * i, 1'b1);
        at(c + 20); check("rep_state", 32'(dut.state_q), 32'(ST_REPEAT));
        at(c + 40); btn_up = 1'b0;
        at(c + 46); check("rep_active_hold", 32'(active), 1);
        at(c + 47); check("rep_active_fall", 32'(active), 0);
        at(c + 65);

        // Both buttons: up, then down while up held -> LOCK.
        c = cyc;
        btn_up = 1'b1;
        push(c + 7, 1'b1);
        at(c + 8);  btn_dn = 1'b1;
        at(c + 14); check("both_state_press", 32'(dut.state_q), 32'(ST_PRESS));
        at(c + 15); check("both_state_lock",  32'(dut.state_q), 32'(ST_LOCK));
                    check("both_active",      32'(active), 0);
        at(c + 25); btn_up = 1'b0;
        at(c + 40); check("lock_up_released", 32'(dut.state_q), 32'(ST_LOCK));
                    btn_dn = 1'b0;
        at(c + 46); check("lock_hold", 32'(dut.state_q), 32'(ST_LOCK));
        at(c + 47); check("lock_exit", 32'(dut.state_q), 32'(ST_IDLE));
        at(c + 50); btn_dn = 1'b1;
        push(c + 57, 1'b0);
        at(c + 55); btn_dn = 1'b0;
        at(c + 57); check("dn_active", 32'(active), 1);
        at(c + 75);

        // Reset mid-hold on the edge a repeat would fall due.
        c = cyc;
        btn_up = 1'b1;
        push(c + 7,  1'b1);
        push(c + 17, 1'b1);
        push(c + 20, 1'b1);
        push(c + 23, 1'b1);
        at(c + 25); rst = 1'b1;
        at(c + 26); rst = 1'b0;
        check("rst_step_up", 32'(step_up), 0);
        check("rst_active",  32'(active), 0);
        check("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
        push(c + 33, 1'b1);
        push(c + 43, 1'b1);
        push(c + 46, 1'b1);
        push(c + 49, 1'b1);
        at(c + 45); btn_up = 1'b0;
        at(c + 70);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
